hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding controller for the 16-bit in-order pipeline (IF, ID, EXE, MEM, WB). It keeps a shadow pipeline of destination-register tags, compares them against the instruction in ID, and drives the pipeline controls:
- stall of IF and IF/ID on a load-use hazard;
- flush of IF/ID on a taken branch;
- bubble insertion into ID/EXE;
- registered per-operand forwarding selects consumed by the EXE operand muxes.

It removes the current fixed pc_en=1 / stop=0 behaviour and generalises it to NSRC operands and NREGS registers.

Parameters:
ARQ, 16, datapath width (only used for hazard_cnt width)
NREGS, 16, architectural register count
RAW, $clog2(NREGS), register-index width
NSRC, 3, number of source operands checked per instruction
ZERO_REG, 1, 1 means register 0 is hardwired zero and never causes a hazard or forward

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  NSRC*RAW  source indices; operand k occupies bits [k*RAW +: RAW]
id_rs_used  in  NSRC  bit k set: operand k is read from the register file
id_rd  in  RAW  destination index
id_wb_en  in  1  instruction writes back
id_is_load  in  1  instruction reads memory (result available after MEM)
exe_branch_taken  in  1  branch resolved taken in EXE this cycle
pc_en  out  1  PC update enable
ifid_stall  out  1  hold the IF/ID register
ifid_flush  out  1  clear the IF/ID register at the next edge
idexe_bubble  out  1  load a NOP into ID/EXE at the next edge
fwd_sel  out  NSRC*2  per operand, valid while the instruction is in EXE: 0 register file, 1 EXE/MEM alu_result, 2 MEM/WB result, 3 reserved (never driven)
hazard_cnt  out  ARQ  saturating count of load-use stall cycles

Behaviour:
- Shadow stages: S_EXE, S_MEM and S_WB, each holding {valid, rd, wb_en, is_load}. Reset clears every valid bit to 0.
- Every edge: S_WB<=S_MEM and S_MEM<=S_EXE.
- S_EXE<={id_valid,id_rd,id_wb_en,id_is_load} unless idexe_bubble=1, in which case S_EXE.valid<=0.
- match(S,k) = S.valid & S.wb_en & id_rs_used[k] & (S.rd==rs_k) & !(ZERO_REG & rs_k==0).
- Load-use: lu = id_valid & OR over k of (match(S_EXE,k) & S_EXE.is_load). The check is combinational, same cycle.
- Branch: br = exe_branch_taken.
- Outputs (combinational):
  - pc_en = !(lu & !br)
  - ifid_stall = lu & !br
  - ifid_flush = br
  - idexe_bubble = br | lu
- Branch beats stall: when br=1 the PC loads the target, the wrong-path ID instruction is dropped, and no stall is counted.
- Forwarding, computed in ID and registered into fwd_sel at the edge on which the instruction enters EXE:
  - sel_k = 1 if match(S_EXE,k) & !S_EXE.is_load;
  - else 2 if match(S_MEM,k);
  - else 0.
  - The younger producer (S_EXE) has priority.
  - If idexe_bubble=1, fwd_sel<=0 for all operands.
- Load-use resolution: after the single stall cycle the load sits in S_MEM and the consumer receives sel=2. The stall latency is exactly 1 cycle per hazard.
- A WB-stage producer is not forwarded. The register file is write-first; this is a system-level requirement on the register file, not checked here.
- hazard_cnt increments by 1 on each edge where lu & !br, and saturates at 2^ARQ-1.
- Reset values: fwd_sel=0, hazard_cnt=0, all shadow valid bits 0. With inputs idle this gives pc_en=1, ifid_stall=0, ifid_flush=0, idexe_bubble=0.
- Reset asserted mid-operation clears the shadow state immediately, so pending hazards are forgotten.
- Back-to-back loads to the same register stall once per dependent consumer.
- id_valid=0 never stalls, but a bubble still propagates through the shadow stages.

Decomposition:
- Package hazard_pkg holds:
  - typedef fwd_sel_t, a 2-bit enum {FWD_RF, FWD_EXEMEM, FWD_MEMWB, FWD_RSVD};
  - struct stage_tag_t {valid, rd, wb_en, is_load};
  - function tag_match.
- One sub-module, hazard_tag_pipe: the three-stage shadow register chain with the bubble input. The compare and priority logic stays in the top.

Test Plan:
1. Dependent ALU ops: r3=r1+r2, then r4=r3+r5 in the next cycle -> second op in EXE sees fwd_sel[0]=1; no stall; hazard_cnt=0.
2. One-instruction gap: r3 producer, unrelated op, then consumer of r3 -> consumer sees fwd_sel=2.
3. Load-use: load r6, then add using r6 -> exactly 1 cycle with pc_en=0, ifid_stall=1, idexe_bubble=1; then consumer sees fwd_sel=2; hazard_cnt=1.
4. Load-use coinciding with exe_branch_taken=1 -> pc_en=1, ifid_flush=1, idexe_bubble=1, ifid_stall=0; hazard_cnt unchanged.
5. r0 as destination and source with ZERO_REG=1 -> fwd_sel=0 and no stall, even right after a load to r0.
6. Drive 3 hazards, assert rst low mid-stall, release -> all outputs at reset values; the first following instruction sees fwd_sel=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding selects,
// shadow-stage destination tags and the tag compare used by every stage.
package hazard_pkg;

    // Tag rd field is sized for up to 256 registers; narrower indices are zero-extended.
    localparam int RD_W = 8;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_EXEMEM = 2'd1,
        FWD_MEMWB  = 2'd2,
        FWD_RSVD   = 2'd3
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wb_en;
        logic            is_load;
    } stage_tag_t;

    function automatic logic tag_match(
        input stage_tag_t      s,
        input logic            used,
        input logic [RD_W-1:0] rs,
        input logic            zero_reg
    );
        return s.valid & s.wb_en & used & (s.rd == rs) & ~(zero_reg & (rs == '0));
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow pipeline of destination tags (EXE, MEM, WB) tracking the datapath.
// A bubble invalidates the tag entering EXE; older stages always advance.
import hazard_pkg::*;

module hazard_tag_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       bubble,
    input  stage_tag_t in_tag,
    output stage_tag_t s_exe,
    output stage_tag_t s_mem,
    output stage_tag_t s_wb
);

    stage_tag_t exe_d;

    always_comb begin
        exe_d       = in_tag;
        exe_d.valid = in_tag.valid & ~bubble;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_exe <= '0;
            s_mem <= '0;
            s_wb  <= '0;
        end else begin
            s_wb  <= s_mem;
            s_mem <= s_exe;
            s_exe <= exe_d;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage in-order pipeline:
// load-use stall, branch flush, ID/EXE bubble and registered operand forwarding selects.
import hazard_pkg::*;

module hazard_fwd_unit #(
    parameter int ARQ      = 16,
    parameter int NREGS    = 16,
    parameter int RAW      = $clog2(NREGS),
    parameter int NSRC     = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NSRC*RAW-1:0] id_rs,
    input  logic [NSRC-1:0]   id_rs_used,
    input  logic [RAW-1:0]    id_rd,
    input  logic              id_wb_en,
    input  logic              id_is_load,
    input  logic              exe_branch_taken,
    output logic              pc_en,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idexe_bubble,
    output logic [NSRC*2-1:0] fwd_sel,
    output logic [ARQ-1:0]    hazard_cnt
);

    stage_tag_t          id_tag;
    stage_tag_t          s_exe;
    stage_tag_t          s_mem;
    logic [NSRC-1:0]     m_exe;
    logic [NSRC-1:0]     m_mem;
    logic                lu;
    logic                br;
    logic [NSRC*2-1:0]   fwd_next;

    always_comb begin
        id_tag         = '0;
        id_tag.valid   = id_valid;
        id_tag.rd      = RD_W'(id_rd);
        id_tag.wb_en   = id_wb_en;
        id_tag.is_load = id_is_load;
    end

    // WB-stage tag is not consulted: the register file is write-first.
    hazard_tag_pipe u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .bubble (idexe_bubble),
        .in_tag (id_tag),
        .s_exe  (s_exe),
        .s_mem  (s_mem),
        .s_wb   ()
    );

    always_comb begin
        m_exe    = '0;
        m_mem    = '0;
        lu       = 1'b0;
        fwd_next = '0;
        for (int k = 0; k < NSRC; k++) begin
            m_exe[k] = tag_match(s_exe, id_rs_used[k], RD_W'(id_rs[k*RAW +: RAW]), ZERO_REG);
            m_mem[k] = tag_match(s_mem, id_rs_used[k], RD_W'(id_rs[k*RAW +: RAW]), ZERO_REG);
            if (m_exe[k] && s_exe.is_load)
                lu = 1'b1;
            // Younger producer in EXE wins over the one in MEM.
            if (m_exe[k] && !s_exe.is_load)
                fwd_next[k*2 +: 2] = FWD_EXEMEM;
            else if (m_mem[k])
                fwd_next[k*2 +: 2] = FWD_MEMWB;
        end
        lu = lu & id_valid;
    end

    assign br           = exe_branch_taken;
    assign ifid_stall   = lu & ~br;
    assign pc_en        = ~ifid_stall;
    assign ifid_flush   = br;
    assign idexe_bubble = br | lu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel    <= '0;
            hazard_cnt <= '0;
        end else begin
            fwd_sel <= idexe_bubble ? '0 : fwd_next;
            if (ifid_stall && (hazard_cnt != '1))
                hazard_cnt <= hazard_cnt + ARQ'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding distances, load-use stall,
// branch priority, zero register, back-to-back loads and mid-run reset.
module tb_hazard_fwd_unit;

    localparam int ARQ  = 16;
    localparam int RAW  = 4;
    localparam int NSRC = 3;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [NSRC*RAW-1:0] id_rs;
    logic [NSRC-1:0] id_rs_used;
    logic [RAW-1:0]  id_rd;
    logic            id_wb_en;
    logic            id_is_load;
    logic            exe_branch_taken;
    logic            pc_en;
    logic            ifid_stall;
    logic            ifid_flush;
    logic            idexe_bubble;
    logic [NSRC*2-1:0] fwd_sel;
    logic [ARQ-1:0]  hazard_cnt;

    int checks = 0;
    int errors = 0;
    logic [ARQ-1:0] exp_cnt = '0;

    hazard_fwd_unit #(
        .ARQ(ARQ), .NREGS(16), .RAW(RAW), .NSRC(NSRC), .ZERO_REG(1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rs_used       (id_rs_used),
        .id_rd            (id_rd),
        .id_wb_en         (id_wb_en),
        .id_is_load       (id_is_load),
        .exe_branch_taken (exe_branch_taken),
        .pc_en            (pc_en),
        .ifid_stall       (ifid_stall),
        .ifid_flush       (ifid_flush),
        .idexe_bubble     (idexe_bubble),
        .fwd_sel          (fwd_sel),
        .hazard_cnt       (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs0, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [2:0] used, input logic [3:0] rd,
                          input logic wb, input logic ld);
        id_valid   = v;
        id_rs      = {rs2, rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_wb_en   = wb;
        id_is_load = ld;
        #1;
    endtask

    task automatic drain();
        exe_branch_taken = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        exe_branch_taken = 1'b0;
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
        repeat (2) tick();
        checks++;
        if (pc_en !== 1'b1 || ifid_stall !== 1'b0 || ifid_flush !== 1'b0 || idexe_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got pc_en=%b stall=%b flush=%b bubble=%b, want 1 0 0 0",
                     pc_en, ifid_stall, ifid_flush, idexe_bubble);
        end
        checks++;
        if (fwd_sel !== '0 || hazard_cnt !== '0) begin
            errors++;
            $display("FAIL reset_regs: got fwd_sel=%b cnt=%0d, want 0 0", fwd_sel, hazard_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_fwd();
        set_id(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd3, 4'd5, 4'd0, 3'b011, 4'd4, 1'b1, 1'b0);
        checks++;
        if (ifid_stall !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL alu_nostall: got stall=%b pc_en=%b, want 0 1", ifid_stall, pc_en);
        end
        tick();
        checks++;
        if (fwd_sel !== 6'b000001) begin
            errors++;
            $display("FAIL alu_fwd: got fwd_sel=%b, want 000001", fwd_sel);
        end
        checks++;
        if (hazard_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL alu_cnt: got %0d, want %0d", hazard_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_gap();
        set_id(1'b1, 4'd1, 4'd2, 4'd0, 3'b011, 4'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd9, 4'd10, 4'd0, 3'b011, 4'd8, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd7, 4'd3, 4'd0, 3'b011, 4'd11, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 6'b001000) begin
            errors++;
            $display("FAIL gap_fwd: got fwd_sel=%b, want 001000", fwd_sel);
        end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd6, 4'd2, 4'd6, 3'b101, 4'd12, 1'b1, 1'b0);
        checks++;
        if (pc_en !== 1'b0 || ifid_stall !== 1'b1 || idexe_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall: got pc_en=%b stall=%b bubble=%b flush=%b, want 0 1 1 0",
                     pc_en, ifid_stall, idexe_bubble, ifid_flush);
        end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (pc_en !== 1'b1 || ifid_stall !== 1'b0 || fwd_sel !== '0 || hazard_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL lu_after: got pc_en=%b stall=%b fwd_sel=%b cnt=%0d, want 1 0 000000 %0d",
                     pc_en, ifid_stall, fwd_sel, hazard_cnt, exp_cnt);
        end
        tick();
        checks++;
        if (fwd_sel !== 6'b100010) begin
            errors++;
            $display("FAIL lu_fwd: got fwd_sel=%b, want 100010", fwd_sel);
        end
        drain();
    endtask

    task automatic test_branch();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b1);
        tick();
        exe_branch_taken = 1'b1;
        set_id(1'b1, 4'd7, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b0);
        checks++;
        if (pc_en !== 1'b1 || ifid_flush !== 1'b1 || idexe_bubble !== 1'b1 || ifid_stall !== 1'b0) begin
            errors++;
            $display("FAIL br_ctrl: got pc_en=%b flush=%b bubble=%b stall=%b, want 1 1 1 0",
                     pc_en, ifid_flush, idexe_bubble, ifid_stall);
        end
        tick();
        checks++;
        if (hazard_cnt !== exp_cnt || fwd_sel !== '0) begin
            errors++;
            $display("FAIL br_cnt: got cnt=%0d fwd_sel=%b, want %0d 000000", hazard_cnt, fwd_sel, exp_cnt);
        end
        drain();
    endtask

    task automatic test_zero_reg();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b011, 4'd0, 1'b1, 1'b0);
        checks++;
        if (ifid_stall !== 1'b0 || pc_en !== 1'b1 || idexe_bubble !== 1'b0) begin
            errors++;
            $display("FAIL zero_nostall: got stall=%b pc_en=%b bubble=%b, want 0 1 0",
                     ifid_stall, pc_en, idexe_bubble);
        end
        tick();
        set_id(1'b1, 4'd0, 4'd0, 4'd0, 3'b111, 4'd2, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== '0) begin
            errors++;
            $display("FAIL zero_fwd: got fwd_sel=%b, want 000000", fwd_sel);
        end
        drain();
    endtask

    task automatic test_priority_idle();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd3, 4'd0, 4'd0, 3'b001, 4'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd4, 4'd2, 4'd2, 3'b110, 4'd9, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== 6'b010100) begin
            errors++;
            $display("FAIL prio_fwd: got fwd_sel=%b, want 010100", fwd_sel);
        end
        drain();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 4'd5, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b0);
        checks++;
        if (ifid_stall !== 1'b0 || idexe_bubble !== 1'b0) begin
            errors++;
            $display("FAIL idle_nostall: got stall=%b bubble=%b, want 0 0", ifid_stall, idexe_bubble);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd4, 1'b1, 1'b1);
        checks++;
        if (ifid_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load_nostall: got stall=%b, want 0", ifid_stall);
        end
        tick();
        set_id(1'b1, 4'd4, 4'd0, 4'd0, 3'b001, 4'd11, 1'b1, 1'b0);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        tick();
        checks++;
        if (fwd_sel !== 6'b000010 || hazard_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_fwd: got fwd_sel=%b cnt=%0d, want 000010 %0d", fwd_sel, hazard_cnt, exp_cnt);
        end
        set_id(1'b1, 4'd0, 4'd4, 4'd0, 3'b010, 4'd12, 1'b1, 1'b0);
        checks++;
        if (ifid_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got stall=%b, want 0", ifid_stall);
        end
        tick();
        checks++;
        if (fwd_sel !== '0 || hazard_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_second_fwd: got fwd_sel=%b cnt=%0d, want 000000 %0d", fwd_sel, hazard_cnt, exp_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int h = 0; h < 2; h++) begin
            set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0);
            tick();
            exp_cnt = exp_cnt + 1'b1;
            tick();
        end
        checks++;
        if (hazard_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL mid_cnt: got %0d, want %0d", hazard_cnt, exp_cnt);
        end
        set_id(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd6, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd6, 4'd0, 4'd0, 3'b001, 4'd7, 1'b1, 1'b0);
        checks++;
        if (ifid_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall: got stall=%b, want 1", ifid_stall);
        end
        rst = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if (pc_en !== 1'b1 || ifid_stall !== 1'b0 || idexe_bubble !== 1'b0 ||
            fwd_sel !== '0 || hazard_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got pc_en=%b stall=%b bubble=%b fwd_sel=%b cnt=%0d, want 1 0 0 000000 0",
                     pc_en, ifid_stall, idexe_bubble, fwd_sel, hazard_cnt);
        end
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        set_id(1'b1, 4'd6, 4'd6, 4'd6, 3'b111, 4'd8, 1'b1, 1'b0);
        tick();
        checks++;
        if (fwd_sel !== '0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_first: got fwd_sel=%b pc_en=%b, want 000000 1", fwd_sel, pc_en);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_gap();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_priority_idle();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
